// File: rtl/seg_scan_driver.sv
// seg_scan_driver: drives a 4-digit multiplexed seven-segment display from
// an upstream 2-bit scan phase. Display data is written through a one-deep
// shadow register (ready/valid) and committed only on a phase wrap (3 -> 0),
// so a frame never mixes old and new digits.
//
// Optional feature: define SEG_DEADTIME_EN to blank the anodes for
// DEAD_CYCLES cycles after every phase change (anti-ghosting).
//
// Parameters:
//   ACTIVE_LOW   1 -> an/seg asserted = 0
//   DEAD_CYCLES  anode-off cycles after a phase change (1..15, SEG_DEADTIME_EN only)
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   phase[1:0]          digit index from the scan counter
//   wr_en, wr_data      write request and four BCD nibbles (digit 0 = [3:0])
//   wr_ready            shadow empty
//   blank_lz            leading-zero blanking enable
//   an[3:0], seg[6:0]   registered anode / segment drives (seg[0] = a)
//   frame_done          one-cycle pulse after each phase wrap
module seg_scan_driver #(
  parameter bit          ACTIVE_LOW  = 1'b1,
  parameter int unsigned DEAD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  phase,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  output logic        wr_ready,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        frame_done
);

  logic [15:0] shadow_q, shadow_d;
  logic [15:0] active_q, active_d;
  logic        pending_q, pending_d;
  logic [1:0]  phase_q;
  logic        wrap;
  logic [15:0] digits_hi;
  logic [3:0]  nibble;
  logic        blank;
  logic [3:0]  an_d;
  logic [6:0]  seg_d;

  // Active-high segment pattern, bit 0 = a ... bit 6 = g. 10..15 show "-".
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] p;
    unique case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h40;
    endcase
    return p;
  endfunction

  assign wr_ready = !pending_q;
  assign wrap     = (phase_q == 2'd3) && (phase == 2'd0);

  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (wrap && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end else if (wr_en && !pending_q) begin
      shadow_d  = wr_data;
      pending_d = 1'b1;
    end

    // Outputs use active_d so the first digit of a freshly committed frame is new.
    digits_hi = active_d >> {phase, 2'b00};
    nibble    = digits_hi[3:0];
    blank     = blank_lz && (phase != 2'd0) && (digits_hi == 16'h0000);
    seg_d     = blank ? 7'h00 : decode(nibble);
    an_d      = 4'b0001 << phase;
  end

`ifdef SEG_DEADTIME_EN
  logic [3:0] dead_q, dead_d;
  logic [3:0] an_gated;

  always_comb begin
    dead_d = dead_q;
    if (phase != phase_q) begin
      dead_d = 4'(DEAD_CYCLES);
    end else if (dead_q != 4'd0) begin
      dead_d = dead_q - 4'd1;
    end
    // With no change this cycle phase == phase_q, so an_d is onehot(phase_q).
    an_gated = (dead_d != 4'd0) ? 4'b0000 : an_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q   <= 16'h0000;
      active_q   <= 16'h0000;
      pending_q  <= 1'b0;
      phase_q    <= 2'd0;
      an         <= ACTIVE_LOW ? 4'hF : 4'h0;
      seg        <= ACTIVE_LOW ? 7'h7F : 7'h00;
      frame_done <= 1'b0;
`ifdef SEG_DEADTIME_EN
      dead_q     <= 4'd0;
`endif
    end else begin
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      phase_q    <= phase;
      seg        <= ACTIVE_LOW ? ~seg_d : seg_d;
      frame_done <= wrap;
`ifdef SEG_DEADTIME_EN
      dead_q     <= dead_d;
      an         <= ACTIVE_LOW ? ~an_gated : an_gated;
`else
      an         <= ACTIVE_LOW ? ~an_d : an_d;
`endif
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (ACTIVE_LOW = 1, DEAD_CYCLES = 2):
// a directed vector table, an optional dead-time sequence, and a randomized
// run checked against a behavioural model of the display rules.
module tb_seg_scan_driver;

  localparam int unsigned Dead = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  phase;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  seg_scan_driver #(
    .ACTIVE_LOW (1'b1),
    .DEAD_CYCLES(Dead)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .phase     (phase),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .blank_lz  (blank_lz),
    .an        (an),
    .seg       (seg),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  ph;
    logic        we;
    logic [15:0] wd;
    logic        blz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        fd;
    logic        rdy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [1:0] p, logic w, logic [15:0] d, logic b,
                              logic [3:0] a, logic [6:0] s, logic f, logic y);
    vec_t v;
    v.rst = r; v.ph = p; v.we = w; v.wd = d; v.blz = b;
    v.an = a; v.seg = s; v.fd = f; v.rdy = y;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Active-high seven-segment reference patterns.
  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  // Behavioural model state.
  int          m_shadow, m_active, m_prev, m_since;
  bit          m_pending;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_fd;

  task automatic model_edge();
    int p, dig;
    bit w, blanked;
    if (rst) begin
      m_shadow = 0; m_active = 0; m_pending = 0; m_prev = 0; m_since = 100;
      e_an = 4'hF; e_seg = 7'h7F; e_fd = 1'b0;
      return;
    end
    p = int'(phase);
    w = (m_prev == 3) && (p == 0);
    e_fd = w;
    if (w && m_pending) begin
      m_active  = m_shadow;
      m_pending = 0;
    end else if (wr_en && !m_pending) begin
      m_shadow  = int'(wr_data);
      m_pending = 1;
    end
    dig     = (m_active / (1 << (4 * p))) % 16;
    blanked = blank_lz && (p > 0) && ((m_active / (1 << (4 * p))) == 0);
    e_seg   = blanked ? 7'h7F : ~pat(dig);
    m_since = (p != m_prev) ? 0 : ((m_since < 100) ? m_since + 1 : 100);
    e_an    = ~(4'b0001 << p);
`ifdef SEG_DEADTIME_EN
    if (m_since < int'(Dead)) e_an = 4'hF;
`endif
    m_prev = p;
  endtask

  initial begin
    rst = 1'b1; phase = 2'd0; wr_en = 1'b0; wr_data = 16'h0; blank_lz = 1'b0;

    //           rst ph  we data     blz  an     seg    fd  rdy
    tbl.push_back(mk(1, 0, 1, 16'h1234, 0, 4'hF, 7'h7F, 0, 1));
    tbl.push_back(mk(1, 1, 1, 16'h1234, 0, 4'hF, 7'h7F, 0, 1));
    tbl.push_back(mk(0, 1, 1, 16'h1234, 0, 4'hD, 7'h40, 0, 0));
    tbl.push_back(mk(0, 2, 1, 16'h9999, 0, 4'hB, 7'h40, 0, 0));
    tbl.push_back(mk(0, 3, 0, 16'h0000, 0, 4'h7, 7'h40, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 4'hE, 7'h19, 1, 1));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 4'hD, 7'h30, 0, 1));
    tbl.push_back(mk(0, 3, 0, 16'h0000, 0, 4'h7, 7'h79, 0, 1));
    tbl.push_back(mk(0, 2, 0, 16'h0000, 0, 4'hB, 7'h24, 0, 1));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 4'hE, 7'h19, 0, 1));
    tbl.push_back(mk(0, 1, 1, 16'h0050, 0, 4'hD, 7'h30, 0, 0));
    tbl.push_back(mk(0, 2, 0, 16'h0000, 0, 4'hB, 7'h24, 0, 0));
    tbl.push_back(mk(0, 3, 0, 16'h0000, 0, 4'h7, 7'h79, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 4'hE, 7'h40, 1, 1));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 1, 4'hD, 7'h12, 0, 1));
    tbl.push_back(mk(0, 2, 0, 16'h0000, 1, 4'hB, 7'h7F, 0, 1));
    tbl.push_back(mk(0, 3, 0, 16'h0000, 1, 4'h7, 7'h7F, 0, 1));
    tbl.push_back(mk(0, 3, 0, 16'h0000, 0, 4'h7, 7'h40, 0, 1));
    tbl.push_back(mk(0, 2, 0, 16'h0000, 0, 4'hB, 7'h40, 0, 1));
    tbl.push_back(mk(0, 3, 0, 16'h0000, 0, 4'h7, 7'h40, 0, 1));
    tbl.push_back(mk(0, 0, 1, 16'hABCD, 0, 4'hE, 7'h40, 1, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 4'hD, 7'h12, 0, 0));
    tbl.push_back(mk(0, 3, 0, 16'h0000, 0, 4'h7, 7'h40, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 4'hE, 7'h3F, 1, 1));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 4'hE, 7'h3F, 0, 1));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 4'hD, 7'h3F, 0, 1));
    tbl.push_back(mk(0, 3, 0, 16'h0000, 0, 4'h7, 7'h3F, 0, 1));
    tbl.push_back(mk(0, 3, 0, 16'h0000, 1, 4'h7, 7'h3F, 0, 1));
    tbl.push_back(mk(0, 0, 1, 16'h0008, 0, 4'hE, 7'h3F, 1, 0));
    tbl.push_back(mk(1, 1, 0, 16'h0000, 0, 4'hF, 7'h7F, 0, 1));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 4'hE, 7'h40, 0, 1));
    tbl.push_back(mk(0, 3, 0, 16'h0000, 0, 4'h7, 7'h40, 0, 1));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 4'hE, 7'h40, 1, 1));

    foreach (tbl[i]) begin
      rst = tbl[i].rst; phase = tbl[i].ph; wr_en = tbl[i].we;
      wr_data = tbl[i].wd; blank_lz = tbl[i].blz;
      step();
      check($sformatf("vec%0d seg", i), 16'(seg), 16'(tbl[i].seg));
      check($sformatf("vec%0d frame_done", i), 16'(frame_done), 16'(tbl[i].fd));
      check($sformatf("vec%0d wr_ready", i), 16'(wr_ready), 16'(tbl[i].rdy));
`ifndef SEG_DEADTIME_EN
      check($sformatf("vec%0d an", i), 16'(an), 16'(tbl[i].an));
`else
      if (tbl[i].rst) check($sformatf("vec%0d an", i), 16'(an), 16'(tbl[i].an));
`endif
    end

`ifdef SEG_DEADTIME_EN
    // 0 -> 1: two dead cycles, then digit 1; a change mid dead-time restarts.
    rst = 1'b1; phase = 2'd0; wr_en = 1'b0; step();
    rst = 1'b0; step(); step();
    check("dead pre", 16'(an), 16'hE);
    phase = 2'd1; step(); check("dead 0->1 a", 16'(an), 16'hF);
    step();               check("dead 0->1 b", 16'(an), 16'hF);
    step();               check("dead 0->1 on", 16'(an), 16'hD);
    phase = 2'd2; step(); check("dead 1->2 a", 16'(an), 16'hF);
    phase = 2'd3; step(); check("dead restart a", 16'(an), 16'hF);
    step();               check("dead restart b", 16'(an), 16'hF);
    step();               check("dead restart on", 16'(an), 16'h7);
`endif

    // Randomized run against the model. Mostly sequential phase to get wraps.
    rst = 1'b1; wr_en = 1'b0; model_edge(); step();
    rst = 1'b0;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 3) != 0) phase = phase + 2'd1;
      else phase = 2'($urandom_range(0, 3));
      wr_en    = $urandom_range(0, 1) == 1;
      wr_data  = 16'($urandom) & {{4{$urandom_range(0, 1) == 1}}, {4{$urandom_range(0, 1) == 1}},
                                  {4{$urandom_range(0, 1) == 1}}, 4'hF};
      blank_lz = $urandom_range(0, 1) == 1;
      model_edge();
      step();
      check($sformatf("rnd%0d an", n), 16'(an), 16'(e_an));
      check($sformatf("rnd%0d seg", n), 16'(seg), 16'(e_seg));
      check($sformatf("rnd%0d frame_done", n), 16'(frame_done), 16'(e_fd));
      check($sformatf("rnd%0d wr_ready", n), 16'(wr_ready), 16'(!m_pending));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Downstream consumer of the 2-bit scan phase counter: it takes the counter's `phase` value and drives a 4-digit multiplexed seven-segment display. Display data is written through a one-deep shadow register with a ready/valid handshake and committed only at frame boundaries (phase wrap 3→0), so a digit never shows mixed old and new data. The block adds BCD decoding, optional leading-zero blanking, a frame-done pulse, and an optional anti-ghosting dead time.

## Interface
- `ACTIVE_LOW`, 1: polarity of `an` and `seg`. 1 means asserted = 0.
- `DEAD_CYCLES`, 2: anode-off cycles after each phase change. Range 1–15. Used only with `SEG_DEADTIME_EN`.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `phase`  in  2  digit index from the upstream scan counter.
- `wr_en`  in  1  write request (valid).
- `wr_data`  in  16  four BCD nibbles; digit 0 = [3:0], digit 3 = [15:12].
- `wr_ready`  out  1  shadow empty; a write is accepted when `wr_en && wr_ready`.
- `blank_lz`  in  1  enable leading-zero blanking. Sampled every cycle.
- `an`  out  4  anode enables, one-hot asserted.
- `seg`  out  7  segments; `seg[0]`=a … `seg[6]`=g.
- `frame_done`  out  1  one-cycle pulse on each phase wrap.

## Operation
- **Registers:** `shadow[15:0]`, `pending`, `active[15:0]`, `phase_q[1:0]`, plus output registers `an`, `seg`, `frame_done`.
- **Reset (sync, `rst`=1 at an edge):**
  - `shadow`=0, `active`=0, `pending`=0, `phase_q`=0.
  - `an` all deasserted, `seg` all deasserted (polarity per `ACTIVE_LOW`), `frame_done`=0.
  - A reset in mid-frame discards any pending write.
- **Handshake:**
  - `wr_ready` = !`pending` (combinational).
  - Accepted write: `shadow`<=`wr_data`, `pending`<=1.
  - `wr_en` while `pending`=1 is ignored, with no side effects.
- **Wrap detection:** `wrap` = (`phase_q`==3 && `phase`==0).
  - Other jumps (e.g. 1→3, 2→0) are phase changes but not wraps.
- **Commit:** on a `wrap` edge with `pending`=1: `active`<=`shadow`, `pending`<=0.
  - Outputs registered at that edge use the new data (bypass), so digit 0 of the new frame is already new.
  - A write accepted on a `wrap` edge (`pending` was 0) commits at the following wrap.
- **frame_done** <= `wrap`, independent of `pending`.
- **Digit select:** registered on every edge from the current `phase` p and `data` (= committed-next `active`):
  - `an` <= onehot(p);
  - `seg` <= decode(`data[4p+3:4p]`).
- **Decode:**
  - 0–9: standard patterns (e.g. 0 = a–f, 1 = b,c, 8 = all).
  - 10–15: g only ("-").
- **Leading-zero blanking:** when `blank_lz`=1, digit i (i=3,2,1) has `seg` all deasserted if its nibble and all higher nibbles are 0. Digit 0 is never blanked. `an` is unaffected.
- **Polarity:** when `ACTIVE_LOW`=1, `an` and `seg` are inverted at the output registers.

## Timing
- Latency from `phase` to `an`/`seg` is 1 cycle. `frame_done` is asserted in the cycle after the edge where `wrap` was true.
- Write to visible data: commit at the next wrap edge, then 1 cycle to the outputs.
- Worst-case write throughput is one write per frame. `wr_ready` rises in the cycle after the commit.
- Holding `phase` constant keeps `an`/`seg` stable. If `phase` is stuck at 0, there is no wrap, so no commit and no `frame_done`.

## Configuration
- **`SEG_DEADTIME_EN` defined:**
  - A phase change (`phase`!=`phase_q`) loads a dead counter with `DEAD_CYCLES`.
  - While the counter is nonzero, `an` is driven all-deasserted and the counter decrements each cycle. `seg` updates normally.
  - A new phase change during dead time reloads the counter.
  - After dead time, `an` shows onehot(`phase_q`).
  - Reset clears the counter.
  - Anode latency after a change becomes `DEAD_CYCLES`+1.
- **Not defined:** no dead counter; `an` follows the 1-cycle rule above.

## Test plan
- **Reset:** assert `rst` for 2 cycles while `wr_en`=1 and `phase` cycles → `an`=4'hF, `seg`=7'h7F (`ACTIVE_LOW`=1), `wr_ready`=1, `frame_done`=0.
- **Write/commit:** write 16'h1234 with `phase`=1 → `wr_ready` drops next cycle. A second write of 16'h9999 is ignored. After 3→0: digit0 `seg`=pattern 4, digit3 = pattern 1, `wr_ready`=1.
- **Blanking:** `active`=16'h0050, `blank_lz`=1 → digits 3,2 blank, digit1 = 5, digit0 = 0. With `blank_lz`=0 → all four shown.
- **Wrap edge cases:** sequence 0,1,3,2,0 → no `frame_done`. Then 3,0 → one 1-cycle `frame_done`. A write on the wrap edge commits at the next wrap.
- **Decode:** nibbles A–F → `seg` asserted = g only.
- **Dead time (`SEG_DEADTIME_EN`, `DEAD_CYCLES`=2):** phase 0→1 → `an` deasserted for 2 cycles, then 4'b1101. A change mid-dead-time restarts the count.
